char_uart_tx: RTL and testbench

- Downstream consumer of the transformer's ASCII character output (lhs or rhs byte stream).
- Buffers characters in a small FIFO and serialises them as 8N1 UART frames on one pin, so the LaTeX text can be read by a terminal instead of sampled off the parallel outputs.
- Sits between transformer output and a spare uio/uo pin at the top level.

---
 rtl/char_uart_tx.sv | 206 ++++++++++++++++++++
 tb/tb_char_uart_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/char_uart_tx.sv
// char_uart_tx: character FIFO followed by an 8N1 UART transmitter.
// It takes the transformer's ASCII byte stream and sends it out on a single
// pin, so a terminal can read the LaTeX text directly.
//
// NUL bytes complete the handshake but are dropped. Character memory padding
// is therefore never sent on the line.
//
// Optional build macro: UART_PARITY_EN
//   defined   -> an even-parity bit is inserted between the data and stop bits
//                (11 bit times per frame)
//   undefined -> strict 8N1 (10 bit times per frame)
//
// Parameters:
//   CLK_DIV    clock cycles per UART bit, 2..65535
//   FIFO_DEPTH character FIFO entries, power of two, 2..16
//
// Transmit FSM:
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | line high, waiting for the FIFO to become non-empty
//   ST_START  | start bit (tx=0) for CLK_DIV cycles
//   ST_DATA   | 8 data bits, LSB first, CLK_DIV cycles each
//   ST_PARITY | even parity over the data byte (UART_PARITY_EN builds only)
//   ST_STOP   | stop bit (tx=1); chains straight into ST_START if a byte waits

module char_uart_tx #(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    char_in,
   input  logic                          char_valid,
   output logic                          char_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [15:0] BAUD_LOAD = 16'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // ------------------------------------------------------------------
   // Character FIFO
   // ------------------------------------------------------------------
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic [7:0]    fifo_head;

   // The extra pointer MSB distinguishes full from empty when the addresses match
   assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_level = wr_ptr - rd_ptr;
   assign char_ready = ~fifo_full;
   assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

   // NUL characters are acknowledged but never stored
   assign push = char_valid && !fifo_full && (char_in != 8'h00);

   // FIFO storage needs no reset; only the pointers define its contents
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[AW-1:0]] <= char_in;
      end
   end

   // Write pointer advances on every stored character
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + PW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------
   state_t      state;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        baud_tc;

`ifdef UART_PARITY_EN
   logic        parity;
`endif

   assign baud_tc = (baud_cnt == 16'd0);
   assign busy    = (state != ST_IDLE) || (fifo_level != '0);

   // Frame sequencing: the baud timer counts down and each state advances at terminal count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         baud_cnt <= 16'd0;
         bit_idx  <= 3'd0;
         shift    <= 8'h00;
         rd_ptr   <= '0;
         tx       <= 1'b1;
`ifdef UART_PARITY_EN
         parity   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               tx <= 1'b1;
               if (!fifo_empty) begin
                  shift    <= fifo_head;
`ifdef UART_PARITY_EN
                  parity   <= ^fifo_head;
`endif
                  rd_ptr   <= rd_ptr + PW'(1);
                  baud_cnt <= BAUD_LOAD;
                  tx       <= 1'b0;
                  state    <= ST_START;
               end
            end

            ST_START: begin
               if (baud_tc) begin
                  baud_cnt <= BAUD_LOAD;
                  bit_idx  <= 3'd0;
                  tx       <= shift[0];
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end

            ST_DATA: begin
               if (baud_tc) begin
                  baud_cnt <= BAUD_LOAD;
                  if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                     tx    <= parity;
                     state <= ST_PARITY;
`else
                     tx    <= 1'b1;
                     state <= ST_STOP;
`endif
                  end else begin
                     shift   <= {1'b0, shift[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end

`ifdef UART_PARITY_EN
            ST_PARITY: begin
               if (baud_tc) begin
                  baud_cnt <= BAUD_LOAD;
                  tx       <= 1'b1;
                  state    <= ST_STOP;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
`endif

            ST_STOP: begin
               if (baud_tc) begin
                  if (!fifo_empty) begin
                     // Chain into the next frame with no idle bit time
                     shift    <= fifo_head;
`ifdef UART_PARITY_EN
                     parity   <= ^fifo_head;
`endif
                     rd_ptr   <= rd_ptr + PW'(1);
                     baud_cnt <= BAUD_LOAD;
                     tx       <= 1'b0;
                     state    <= ST_START;
                  end else begin
                     tx    <= 1'b1;
                     state <= ST_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end

            default: begin
               tx    <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_char_uart_tx.sv
// Directed testbench for char_uart_tx at CLK_DIV=4 and FIFO_DEPTH=4.
// Build with UART_PARITY_EN defined to exercise the parity frame as well.

module tb_char_uart_tx;

   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 4;
`ifdef UART_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] char_in;
   logic       char_valid;
   logic       char_ready;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_level;

   int vectors;
   int miscompares;

   char_uart_tx #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a start bit, then sample each bit near its middle.
   // On return the bench sits 1.5 cycles into the stop bit.
   task automatic recv(input int budget, output logic [7:0] b, output int waited);
      waited = 0;
      b      = 8'h00;
      while (tx !== 1'b0 && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      chk("recv_start_seen", {31'd0, tx === 1'b0}, 32'd1);
      if (tx === 1'b0) begin
         @(negedge clk);
         chk("recv_start_bit", tx, 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (CLK_DIV) @(negedge clk);
            b[i] = tx;
         end
`ifdef UART_PARITY_EN
         repeat (CLK_DIV) @(negedge clk);
         chk("recv_parity_bit", tx, ^b);
`endif
         repeat (CLK_DIV) @(negedge clk);
         chk("recv_stop_bit", tx, 1'b1);
      end
   endtask

   logic [7:0]  seq [6];
   logic [10:0] fr;
   logic [7:0]  rx_b;
   int          waited;
   int          lows;
   int          idx;
   int          guard;
   int          stalls;
   int          maxlvl;
   bit          saw_low;
   bit          rdy;

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      char_in     = 8'h00;
      char_valid  = 1'b0;
      seq[0] = 8'h5C; seq[1] = 8'h66; seq[2] = 8'h72;
      seq[3] = 8'h61; seq[4] = 8'h63; seq[5] = 8'h7B;

      // ---- reset values and idle line ----
      repeat (3) @(negedge clk);
      chk("rst_tx",         tx,         1'b1);
      chk("rst_busy",       busy,       1'b0);
      chk("rst_char_ready", char_ready, 1'b1);
      chk("rst_fifo_level", fifo_level, 3'd0);
      rst = 1'b0;
      lows = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("idle_tx_low_samples", lows, 0);
      chk("idle_busy", busy, 1'b0);

      // ---- single character 0x41, cycle-exact waveform ----
      char_in    = 8'h41;
      char_valid = 1'b1;
      @(negedge clk);                     // accepted at E0
      char_valid = 1'b0;
      char_in    = 8'h00;
      chk("single_e0_tx",    tx,         1'b1);
      chk("single_e0_level", fifo_level, 3'd1);
      chk("single_e0_busy",  busy,       1'b1);
      fr      = '1;
      fr[0]   = 1'b0;                     // start
      fr[8:1] = 8'h41;                    // data, LSB first: 1,0,0,0,0,0,1,0
`ifdef UART_PARITY_EN
      fr[9]   = 1'b0;                     // 0x41 has two ones -> even parity 0
`endif
      for (int k = 0; k < NB * CLK_DIV; k++) begin
         @(negedge clk);
         chk($sformatf("single_sample_%0d", k), tx, fr[k / CLK_DIV]);
         if (k == NB * CLK_DIV - 1) chk("single_busy_last", busy, 1'b1);
      end
      @(negedge clk);
      chk("single_done_busy", busy, 1'b0);
      chk("single_done_tx",   tx,   1'b1);

`ifdef UART_PARITY_EN
      // ---- parity 1 case: 0x43 has three ones ----
      char_in    = 8'h43;
      char_valid = 1'b1;
      @(negedge clk);
      char_valid = 1'b0;
      recv(10, rx_b, waited);
      chk("parity43_byte", rx_b, 8'h43);
      repeat (5) @(negedge clk);
`endif

      // ---- back-to-back with FIFO full: producer and receiver in parallel ----
      fork
         begin
            idx     = 0;
            guard   = 0;
            stalls  = 0;
            maxlvl  = 0;
            saw_low = 1'b0;
            char_in    = seq[0];
            char_valid = 1'b1;
            while (idx < 6 && guard < 2000) begin
               guard++;
               if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
               if (!char_ready) saw_low = 1'b1;
               rdy = char_ready;
               if (!rdy && idx == 5) stalls++;
               @(negedge clk);
               if (rdy) begin
                  idx++;
                  if (idx < 6) char_in = seq[idx];
               end
            end
            char_valid = 1'b0;
            char_in    = 8'h00;
            chk("b2b_all_accepted", idx,     6);
            chk("b2b_max_level",    maxlvl,  4);
            chk("b2b_ready_low",    saw_low, 1'b1);
            chk("b2b_sixth_held",   {31'd0, stalls > 0}, 32'd1);
         end
         begin
            for (int f = 0; f < 6; f++) begin
               recv((f == 0) ? 20 : 10, rx_b, waited);
               chk($sformatf("b2b_byte_%0d", f), rx_b, seq[f]);
               if (f > 0) chk($sformatf("b2b_gap_%0d", f), waited, 3);
            end
         end
      join
      repeat (4) @(negedge clk);
      chk("b2b_done_busy", busy, 1'b0);

      // ---- NUL filter: 0x00, 0x7B, 0x00 ----
      char_in    = 8'h00;
      char_valid = 1'b1;
      @(negedge clk);
      chk("nul_level_a", fifo_level, 3'd0);
      char_in = 8'h7B;
      @(negedge clk);
      chk("nul_level_b", fifo_level, 3'd1);
      char_in = 8'h00;
      @(negedge clk);
      chk("nul_level_c", fifo_level, 3'd0);
      char_valid = 1'b0;
      recv(10, rx_b, waited);
      chk("nul_byte", rx_b, 8'h7B);
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("nul_no_extra_frame", lows, 0);
      chk("nul_done_busy", busy, 1'b0);

      // ---- reset mid-frame during data bit 3 ----
      char_in    = 8'h41;
      char_valid = 1'b1;
      @(negedge clk);
      char_in = 8'h42;
      @(negedge clk);                     // tx fell at this edge: sample index 0
      char_valid = 1'b0;
      char_in    = 8'h00;
      repeat (17) @(negedge clk);         // middle of data bit 3
      chk("midrst_bit3_tx",    tx,         1'b0);
      chk("midrst_pre_level",  fifo_level, 3'd1);
      rst = 1'b1;
      #1;
      chk("midrst_tx",         tx,         1'b1);
      chk("midrst_level",      fifo_level, 3'd0);
      chk("midrst_busy",       busy,       1'b0);
      chk("midrst_char_ready", char_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("midrst_no_resume", lows, 0);
      chk("midrst_idle_busy", busy, 1'b0);
      char_in    = 8'h33;
      char_valid = 1'b1;
      @(negedge clk);
      char_valid = 1'b0;
      char_in    = 8'h00;
      recv(10, rx_b, waited);
      chk("midrst_new_byte", rx_b, 8'h33);
      repeat (6) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
